// File: rtl/instr_fetch.sv
// instr_fetch: IF stage, owns the 8-bit PC and the IF/ID register.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enable          start fetching (sampled in IDLE only)
//   stall           hold PC and IF/ID
//   br_taken        redirect from EX, wins over stall
//   br_target[7:0]  redirect address
//   imem_addr[7:0]  instruction memory address (= PC)
//   imem_rdata[15:0] instruction word for imem_addr
//   id_instr/id_pc/id_valid  IF/ID register
//   halted          HALT fetched, fetch frozen

package instr_fetch_pkg;

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } fetch_state_e;

  localparam logic [4:0] OP_HALT = 5'b00001;

endpackage

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] id_instr,
  output logic [7:0]  id_pc,
  output logic        id_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  if_id_t       ifid_q, ifid_d;
  if_id_t       nop;
  logic         is_halt;
  logic         fetch_ld;
  logic         stall_cyc;

  assign nop = '{instr: NOP_WORD, pc: 8'h00, valid: 1'b0};

  assign is_halt = (imem_rdata[15:11] == OP_HALT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    fetch_ld  = 1'b0;
    stall_cyc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ifid_d = nop;
        if (enable) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          br_taken: begin
            pc_d   = br_target;
            ifid_d = nop;
          end
          (!br_taken && stall): begin
            stall_cyc = 1'b1;
          end
          default: begin
            fetch_ld = 1'b1;
            ifid_d   = '{instr: imem_rdata,
                         pc:    pc_q,
                         valid: 1'b1};
            // HALT stays at its own address
            if (is_halt) begin
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
        endcase
      end
      S_HALT: begin
        // a redirect here means the HALT was wrong-path
        if (br_taken) begin
          pc_d    = br_target;
          ifid_d  = nop;
          state_d = S_RUN;
        end else if (!stall) begin
          ifid_d = nop;
        end
      end
      default: begin
        state_d = S_IDLE;
        ifid_d  = nop;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP_WORD,
                   pc:    8'h00,
                   valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = ifid_q.instr;
  assign id_pc     = ifid_q.pc;
  assign id_valid  = ifid_q.valid;
  assign halted    = (state_q == S_HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q;
  logic [15:0] scnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 16'h0000;
      scnt_q <= 16'h0000;
    end else begin
      if (fetch_ld && (fcnt_q != 16'hFFFF)) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
      if (stall_cyc && (scnt_q != 16'hFFFF)) begin
        scnt_q <= scnt_q + 16'd1;
      end
    end
  end

  assign perf_fetch_cnt = fcnt_q;
  assign perf_stall_cnt = scnt_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_ld ^ stall_cyc;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch.
// Memory model is combinational; outputs sampled 1ns after posedge.

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  logic [15:0] mem [256];
  int n_vec;
  int n_bad;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .halted     (halted)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h4000 | 16'(i);
    end
    mem[0]     = 16'h4f10;
    mem[1]     = 16'h81b6;
    mem[2]     = 16'h1970;
    mem[8'h69] = 16'h0800;

    rst_n     = 1'b0;
    enable    = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 8'h00;
    #12;
    check("rst_addr",  16'(imem_addr), 16'h0000);
    check("rst_instr", id_instr,       16'h0000);
    check("rst_pc",    16'(id_pc),     16'h0000);
    check("rst_valid", 16'(id_valid),  16'h0000);
    check("rst_halt",  16'(halted),    16'h0000);
`ifdef FETCH_PERF_EN
    check("rst_pfc", perf_fetch_cnt, 16'h0000);
    check("rst_psc", perf_stall_cnt, 16'h0000);
`endif
    #1 rst_n = 1'b1;

    // idle holds until enable
    step();
    check("idle_addr", 16'(imem_addr), 16'h0000);
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("run0_valid", 16'(id_valid), 16'h0000);

    // sequential fetch
    step();
    check("f0_instr", id_instr,      16'h4f10);
    check("f0_pc",    16'(id_pc),    16'h0000);
    check("f0_valid", 16'(id_valid), 16'h0001);
    step();
    check("f1_instr", id_instr,       16'h81b6);
    check("f1_pc",    16'(id_pc),     16'h0001);
    check("f1_addr",  16'(imem_addr), 16'h0002);

    // two stall cycles
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("st_instr", id_instr,       16'h81b6);
      check("st_addr",  16'(imem_addr), 16'h0002);
      check("st_valid", 16'(id_valid),  16'h0001);
    end
    stall = 1'b0;
    step();
    check("f2_instr", id_instr,       16'h1970);
    check("f2_pc",    16'(id_pc),     16'h0002);
    check("f2_addr",  16'(imem_addr), 16'h0003);

    // redirect beats stall
    br_taken  = 1'b1;
    br_target = 8'h51;
    stall     = 1'b1;
    step();
    br_taken = 1'b0;
    stall    = 1'b0;
    check("br_valid", 16'(id_valid),  16'h0000);
    check("br_addr",  16'(imem_addr), 16'h0051);
    step();
    check("br_pc",    16'(id_pc),    16'h0051);
    check("br_instr", id_instr,      16'h4051);
    check("br_v1",    16'(id_valid), 16'h0001);

    // wrap FF -> 00
    br_taken  = 1'b1;
    br_target = 8'hFE;
    step();
    br_taken = 1'b0;
    step();
    check("w_fe", 16'(id_pc), 16'h00FE);
    step();
    check("w_ff",   16'(id_pc),     16'h00FF);
    check("w_addr", 16'(imem_addr), 16'h0000);
    step();
    check("w_00", id_instr, 16'h4f10);

    // HALT at 69
    br_taken  = 1'b1;
    br_target = 8'h68;
    step();
    br_taken = 1'b0;
    step();
    check("h_pre", 16'(halted), 16'h0000);
    step();
    check("h_instr", id_instr,       16'h0800);
    check("h_pc",    16'(id_pc),     16'h0069);
    check("h_halt",  16'(halted),    16'h0001);
    check("h_addr",  16'(imem_addr), 16'h0069);
    for (int k = 0; k < 3; k++) begin
      step();
      check("h_valid", 16'(id_valid),  16'h0000);
      check("h_hold",  16'(imem_addr), 16'h0069);
      check("h_stay",  16'(halted),    16'h0001);
    end

    // redirect out of HALTED
    br_taken  = 1'b1;
    br_target = 8'h10;
    step();
    br_taken = 1'b0;
    check("hb_halt", 16'(halted),    16'h0000);
    check("hb_addr", 16'(imem_addr), 16'h0010);
    step();
    check("hb_pc",    16'(id_pc),    16'h0010);
    check("hb_valid", 16'(id_valid), 16'h0001);

    // async reset mid-run, no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("ar_addr",  16'(imem_addr), 16'h0000);
    check("ar_valid", 16'(id_valid),  16'h0000);
    check("ar_halt",  16'(halted),    16'h0000);
    #1 rst_n = 1'b1;
    step();
    step();
    check("ar_idle", 16'(imem_addr), 16'h0000);
    check("ar_iv",   16'(id_valid),  16'h0000);

    // 5 fetches then 3 stalls
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("p_pc",   16'(id_pc),     16'h0004);
    check("p_addr", 16'(imem_addr), 16'h0005);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) step();
    stall = 1'b0;
    check("p_spc", 16'(id_pc),     16'h0004);
    check("p_sad", 16'(imem_addr), 16'h0005);
`ifdef FETCH_PERF_EN
    check("p_fcnt", perf_fetch_cnt, 16'd5);
    check("p_scnt", perf_stall_cnt, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit pipelined CPU. Holds the 8-bit program counter, drives the instruction memory's combinational read address, and registers the returned 16-bit instruction into the IF/ID pipeline register for decode. Handles hazard stalls, branch/jump redirects from the execute stage, and HALT detection.

## Interface
- `RESET_PC`, 8'h00: PC value after reset.
- `NOP_WORD`, 16'h0000: word inserted into IF/ID on flush or bubble (opcode NOP = 5'b00000).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  level; start fetching when high in IDLE.
- `stall`  in  1  hazard unit; hold PC and IF/ID contents.
- `br_taken`  in  1  redirect request from EX (JUMP, JMPR, taken Bxx).
- `br_target`  in  8  redirect address, valid with `br_taken`.
- `imem_addr`  out  8  instruction memory read address; equals PC register.
- `imem_rdata`  in  16  instruction word, combinational from `imem_addr`.
- `id_instr`  out  16  IF/ID instruction.
- `id_pc`  out  8  address `id_instr` was fetched from.
- `id_valid`  out  1  IF/ID holds a real (non-bubble) instruction.
- `halted`  out  1  HALT fetched; fetch stopped.

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- Reset values: PC = `RESET_PC`, `id_instr` = `NOP_WORD`, `id_pc` = 0, `id_valid` = 0, `halted` = 0.
- IDLE: PC held, IF/ID loads NOP with `id_valid`=0. `enable`=1 -> RUN next cycle; first fetch happens in the first RUN cycle.
- RUN, per cycle, in priority order:
  1. `br_taken`: PC <= `br_target`; IF/ID <= NOP, `id_valid`=0. Overrides `stall`.
  2. `stall`: PC, `id_instr`, `id_pc`, `id_valid` all hold.
  3. Otherwise: IF/ID <= {`imem_rdata`, PC, valid=1}; PC <= PC+1 (8-bit, 8'hFF wraps to 8'h00).
- HALT detection: in case 3, if `imem_rdata[15:11]` == 5'b00001, HALT is loaded into IF/ID normally, PC is not incremented, and the state becomes HALTED. A HALT on `imem_rdata` during a stall or redirect cycle is not detected (it is either refetched or wrong-path).
- HALTED: `halted`=1; PC frozen at the HALT address; IF/ID loads NOP, `id_valid`=0, once not stalled. A `br_taken` in HALTED (older branch resolves and the HALT was wrong-path) applies the redirect and returns to RUN with `halted`=0.
- `enable` is sampled only in IDLE. Leaving HALTED other than by redirect requires `rst_n`.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no partial IF/ID update.

## Timing
- `imem_addr` is combinational from the PC register, with no delay through the fetch logic. The instruction at address A appears on `id_instr` the edge after PC=A, provided that cycle is not stalled or redirected.
- Redirect penalty: `br_taken` in cycle N -> `id_valid`=0 in N+1; target instruction in IF/ID at N+2.
- Stall is cycle-exact: k stall cycles delay all outputs by k cycles.
- `halted` rises on the same edge that loads HALT into IF/ID.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetch_cnt[15:0]`, incremented on every case-3 load (including HALT).
  - Adds outputs `perf_stall_cnt[15:0]`, incremented on every RUN cycle with `stall`=1 and `br_taken`=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Sequential fetch: memory holds 4f10, 81b6, 1970 at 0..2; assert `enable` -> `id_instr` shows 4f10/81b6/1970 with `id_pc` 0/1/2 on consecutive cycles, `id_valid`=1.
- Stall: `stall` high for 2 cycles while `id_pc`=1 -> `id_instr` holds 81b6 and `imem_addr` holds 2 for both cycles, then resumes with 1970.
- Redirect priority: `br_taken`=1, `br_target`=8'h51, with `stall`=1 in the same cycle -> next cycle `id_valid`=0 and `imem_addr`=8'h51; following cycle `id_pc`=8'h51.
- HALT: 16'h0800 at address 8'h69 -> `id_instr`=0800, `halted`=1 on the same edge; `imem_addr` stays 8'h69; following `id_valid`=0 indefinitely.
- Wrap and reset: PC at 8'hFF fetched -> next `imem_addr`=8'h00. Drop `rst_n` mid-run -> `imem_addr`=`RESET_PC`, `id_valid`=0, state IDLE without waiting for a clock edge.
- `FETCH_PERF_EN`: 5 fetches plus 3 stall cycles -> `perf_fetch_cnt`=5, `perf_stall_cnt`=3.
